// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: register addresses,
// measurement FSM states and status word layout.
package pwm_capture_pkg;

    localparam logic [2:0] ADDR_PERIOD       = 3'd0;
    localparam logic [2:0] ADDR_SHADOW_HIGH  = 3'd1;
    localparam logic [2:0] ADDR_STATUS       = 3'd2;
    localparam logic [2:0] ADDR_CONTROL      = 3'd3;
    localparam logic [2:0] ADDR_SAMPLE_COUNT = 3'd4;
    localparam logic [2:0] ADDR_CLEAR        = 3'd5;
    localparam logic [2:0] ADDR_CLOCK_HZ     = 3'd6;
    localparam logic [2:0] ADDR_HIGH_LIVE    = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    localparam int STAT_VALID   = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_LEVEL   = 2;
    localparam int STAT_ENABLE  = 3;

    // Builds the status word from its individual flags.
    function automatic logic [31:0] packStatus(input logic valid,
                                               input logic timedOut,
                                               input logic level,
                                               input logic enable);
        logic [31:0] s;
        s               = '0;
        s[STAT_VALID]   = valid;
        s[STAT_TIMEOUT] = timedOut;
        s[STAT_LEVEL]   = level;
        s[STAT_ENABLE]  = enable;
        return s;
    endfunction

endpackage

// File: rtl/pwm_capture_input_filter.sv
// Synchroniser plus glitch filter for the asynchronous PWM input.
// The filtered level only moves after FILTER_LEN consecutive synced samples
// disagree with it, so edge latency is a constant SYNC_STAGES+FILTER_LEN.
module pwm_input_filter
    import pwm_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [RUN_W-1:0]       r_run;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;

    // Shift the raw input through the metastability chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_pwm;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Count disagreeing samples and flip the level (with an edge strobe) once the run is long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_synced != r_level) begin
                if (r_run == RUN_W'(FILTER_LEN - 1)) begin
                    r_level <= w_synced;
                    r_run   <= '0;
                    r_rise  <= w_synced;
                    r_fall  <= ~w_synced;
                end else begin
                    r_run <= r_run + RUN_W'(1);
                end
            end else begin
                r_run <= '0;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Avalon-MM slave measuring PWM period and high time in clk ticks, with a
// stuck-level timeout. Software derives duty from the period/high pair.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED_HZ = 50_000_000,
    parameter int unsigned TIMEOUT_TICKS  = 50_000_000,
    parameter int          SYNC_STAGES    = 2,
    parameter int          FILTER_LEN     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic        pwm_in,
    output logic        sample_valid,
    output logic        new_sample
);

    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_TICKS);

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [31:0] r_hcnt;
    logic [31:0] r_period;
    logic [31:0] r_high;
    logic [31:0] r_shadowHigh;
    logic [31:0] r_sampleCount;
    logic        r_timeout;
    logic        r_enable;
    logic        r_sampleValid;
    logic        r_newSample;
    logic [31:0] r_readdata;
    logic        r_rdAck;

    logic        w_level;
    logic        w_rise;
    logic        w_fall;
    logic        w_cntSat;
    logic        w_clearWrite;
    logic [31:0] w_readMux;
    logic        w_unusedWriteBits;

    pwm_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk    (clk),
        .reset  (reset),
        .i_pwm  (pwm_in),
        .o_level(w_level),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_cntSat          = (r_cnt >= TIMEOUT_LIM);
    assign w_clearWrite      = write && (address == ADDR_CLEAR);
    assign w_unusedWriteBits = ^writedata[31:1];
    assign waitrequest       = read & ~r_rdAck;
    assign readdata          = r_readdata;
    assign sample_valid      = r_sampleValid;
    assign new_sample        = r_newSample;

    // Measurement FSM plus control/clear register writes; a clear overrides a same-cycle capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_hcnt        <= '0;
            r_period      <= '0;
            r_high        <= '0;
            r_sampleCount <= '0;
            r_timeout     <= 1'b0;
            r_enable      <= 1'b0;
            r_sampleValid <= 1'b0;
            r_newSample   <= 1'b0;
        end else begin
            r_newSample <= 1'b0;
            if (!r_enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_hcnt  <= '0;
            end else if (r_state == IDLE) begin
                r_state <= WAIT_RISE;
                r_cnt   <= '0;
            end else if (r_state == WAIT_RISE && w_rise) begin
                r_state <= HIGH;
                r_cnt   <= 32'd1;
            end else if (r_state == HIGH && w_fall) begin
                r_hcnt  <= r_cnt;
                r_cnt   <= w_cntSat ? r_cnt : r_cnt + 32'd1;
                r_state <= LOW;
            end else if (r_state == LOW && w_rise) begin
                r_period      <= r_cnt;
                r_high        <= r_hcnt;
                r_sampleValid <= 1'b1;
                r_newSample   <= 1'b1;
                r_sampleCount <= r_sampleCount + 32'd1;
                r_timeout     <= 1'b0;
                r_cnt         <= 32'd1;
                r_state       <= HIGH;
            end else if (w_cntSat) begin
                r_timeout     <= 1'b1;
                r_sampleValid <= 1'b0;
                r_period      <= '0;
                r_high        <= '0;
                r_hcnt        <= '0;
                r_cnt         <= '0;
                r_state       <= WAIT_RISE;
            end else begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (write && address == ADDR_CONTROL) begin
                r_enable <= writedata[0];
            end
            if (w_clearWrite) begin
                r_sampleCount <= '0;
                r_timeout     <= 1'b0;
            end
        end
    end

    // Select the register addressed by the current read.
    always_comb begin
        w_readMux = '0;
        case (address)
            ADDR_PERIOD:       w_readMux = r_period;
            ADDR_SHADOW_HIGH:  w_readMux = r_shadowHigh;
            ADDR_STATUS:       w_readMux = packStatus(r_sampleValid, r_timeout, w_level, r_enable);
            ADDR_CONTROL:      w_readMux = {31'd0, r_enable};
            ADDR_SAMPLE_COUNT: w_readMux = r_sampleCount;
            ADDR_CLOCK_HZ:     w_readMux = 32'(CLOCK_SPEED_HZ);
            ADDR_HIGH_LIVE:    w_readMux = r_high;
            default:           w_readMux = '0;
        endcase
    end

    // One wait cycle per read; a period read snapshots the matching high time into the shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata   <= '0;
            r_rdAck      <= 1'b0;
            r_shadowHigh <= '0;
        end else begin
            r_rdAck <= read;
            if (read && !r_rdAck) begin
                r_readdata <= w_readMux;
                if (address == ADDR_PERIOD) begin
                    r_shadowHigh <= r_high;
                end
            end
        end
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Avalon-MM slave that measures an incoming PWM waveform: period and high time in clk ticks, plus a stuck-level/timeout status.
- It is the receive-side counterpart of the fan PWM generator. It is used for fan tach/PWM loopback checks and for reading external PWM sources (RC receivers, motor-driver feedback) from the HPS.
- Duty computation is left to software; the block does no division.

Parameters:
- CLOCK_SPEED_HZ, 50_000_000, clk frequency; informational, readable at address 6.
- TIMEOUT_TICKS, 50_000_000, ticks without an edge before timeout is declared; must be < 2^32.
- SYNC_STAGES, 2, input synchroniser depth.
- FILTER_LEN, 4, consecutive equal samples needed to accept a level change.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- address  in  3  Avalon word address
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- read  in  1  Avalon read strobe
- readdata  out  32  Avalon read data
- waitrequest  out  1  Avalon wait
- pwm_in  in  1  asynchronous PWM input
- sample_valid  out  1  high while period/high registers hold a valid measurement
- new_sample  out  1  one-cycle pulse when a new measurement is latched

Behaviour:
- Reset values: readdata=0, sample_valid=0, new_sample=0, period=0, high=0, shadow_high=0, sample_count=0, timeout=0, enable=0, FSM=IDLE.
- Input path:
  - SYNC_STAGES flops, then the glitch filter.
  - Filtered level toggles only after FILTER_LEN consecutive synced samples differ from the current filtered level.
  - Edge-to-filtered-edge latency is SYNC_STAGES+FILTER_LEN cycles. It is constant and cancels out of the measurements.
- Counter: single 32-bit tick counter `cnt` and high-time capture `hcnt`, both saturating at TIMEOUT_TICKS.
- FSM states:
  - IDLE: enable=0; counters held at 0. On enable=1 -> WAIT_RISE.
  - WAIT_RISE: discards the partial first period. On filtered rise -> HIGH with cnt=1.
  - HIGH: cnt++. On filtered fall -> hcnt=cnt, then LOW.
  - LOW: cnt++. On filtered rise:
    - period<=cnt, high<=hcnt, sample_valid<=1, new_sample pulse, sample_count++, timeout<=0.
    - cnt<=1, stay in HIGH (back-to-back periods, no lost cycle).
  - Timeout: in WAIT_RISE/HIGH/LOW, when cnt reaches TIMEOUT_TICKS:
    - timeout<=1, sample_valid<=0, period<=0, high<=0; level bit = current filtered level.
    - -> WAIT_RISE.
  - enable<=0 from any state -> IDLE next cycle. Last period/high/sample_valid are retained.
- Register map (32-bit, address):
  - 0 period (RO); a read also copies high into shadow_high.
  - 1 shadow_high (RO); gives a coherent pair when read after address 0.
  - 2 status (RO): bit0 sample_valid, bit1 timeout, bit2 filtered level, bit3 enable.
  - 3 control (RW): bit0 enable.
  - 4 sample_count (RO, wraps at 2^32).
  - 5 clear (WO): any write zeroes sample_count and timeout.
  - 6 CLOCK_SPEED_HZ (RO).
  - 7 live high (RO).
- Read handshake:
  - waitrequest = read & ~rd_ack.
  - rd_ack registers one cycle after read rises, so waitrequest is high for exactly one cycle.
  - readdata is registered and valid in the cycle waitrequest is low.
  - rd_ack clears when read drops.
  - Unmapped reads return 0.
- Write handshake: writes have no wait. Writes to RO addresses are ignored.
- Simultaneous events:
  - A clear write in the same cycle as a capture leaves sample_count=0; period/high still update.
  - A capture in the same cycle as a read of address 0 returns the old period. shadow_high gets the old high, keeping the pair coherent.
- Reset mid-operation: everything returns to reset values. The first period after release is discarded via WAIT_RISE.

Decomposition:
- Shared package pwm_capture_pkg:
  - address constants ADDR_PERIOD..ADDR_HIGH_LIVE
  - state enum {IDLE, WAIT_RISE, HIGH, LOW}
  - status bit positions
- Sub-module pwm_input_filter (synchroniser + glitch filter, params SYNC_STAGES/FILTER_LEN).
  - Outputs: level, rise, fall strobes.

Test Plan (TIMEOUT_TICKS=1000, FILTER_LEN=4, SYNC_STAGES=2):
- Reset, then read addresses 0-4 -> all return 0; waitrequest high exactly 1 cycle per read.
- Write 1 to address 3; drive pwm_in with 100-cycle period, 30 high, for 3 periods -> after 2nd rise: period=100, shadow_high=30, new_sample pulsed once, status=0b1101 or 0b1001 depending on the level bit, sample_count=2 after 3rd rise.
- During LOW phase, inject a 3-cycle high glitch -> ignored, period stays 100. Then inject a 5-cycle pulse -> accepted as an edge, producing a short measured period.
- Hold pwm_in high 1500 cycles -> at 1000 ticks: timeout=1, sample_valid=0, period=0, level=1. Resume PWM -> timeout clears at the 2nd rise.
- Write any value to address 5 on the same cycle as a capture -> sample_count=0, period updated. Write to address 0 -> no change.
- Assert reset mid-HIGH -> all registers 0, FSM=IDLE. Re-enable -> first partial period not reported.
